// File: rtl/online_arith_pkg.sv
// Shared types and helpers for the online (MSD-first) signed-digit arithmetic datapath.
// Holds the digit-serial adder state encoding and the transfer/interim digit selection
// used by the serial adder; sd_select is written width-generic for multi-operand adders.
package online_arith_pkg;

  // Working width for sd_select; wide enough for any practical RADIX_BITS.
  localparam int SD_MAXW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } adder_state_t;

  typedef struct packed {
    logic signed [1:0]         t;
    logic signed [SD_MAXW-1:0] w;
  } sd_sel_t;

  // Radix r for two's complement digits of radix_bits bits.
  function automatic int sd_radix(input int radix_bits);
    return 1 << (radix_bits - 1);
  endfunction

  // Largest digit magnitude, r-1.
  function automatic int sd_digit_max(input int radix_bits);
    return sd_radix(radix_bits) - 1;
  endfunction

  // Split a digit-pair sum into transfer t and interim w with |w| <= r-2,
  // so that w plus the next transfer can never leave the digit set.
  function automatic sd_sel_t sd_select(input logic signed [SD_MAXW-1:0] s,
                                        input int radix);
    logic signed [SD_MAXW-1:0] r;
    logic signed [SD_MAXW-1:0] dmax;
    sd_sel_t res;
    r    = SD_MAXW'(radix);
    dmax = SD_MAXW'(radix - 1);
    if (s >= dmax) begin
      res.t = 2'sd1;
      res.w = s - r;
    end else if (s <= -dmax) begin
      res.t = -2'sd1;
      res.w = s + r;
    end else begin
      res.t = 2'sd0;
      res.w = s;
    end
    return res;
  endfunction

endpackage

// File: rtl/sd_digit_select.sv
// Combinational transfer/interim selection for one signed-digit pair.
// Latency: none (purely combinational).
// Backpressure: none; the caller decides when the result is consumed.
// Ports: a, b  - signed input digits (RADIX_BITS each)
//        t     - transfer digit in {-1,0,1} (2-bit signed)
//        w     - interim digit, |w| <= r-2 (RADIX_BITS signed)
module sd_digit_select
  import online_arith_pkg::*;
#(
  parameter int RADIX_BITS = 3
) (
  input  logic [RADIX_BITS-1:0] a,
  input  logic [RADIX_BITS-1:0] b,
  output logic [1:0]            t,
  output logic [RADIX_BITS-1:0] w
);

  localparam int RADIX = sd_radix(RADIX_BITS);

  logic signed [RADIX_BITS:0] s;
  sd_sel_t                    sel;

  always_comb begin
    // One extra bit holds the full range of a+b.
    s   = (RADIX_BITS+1)'($signed(a)) + (RADIX_BITS+1)'($signed(b));
    sel = sd_select(SD_MAXW'(s), RADIX);
    t   = sel.t;
    w   = RADIX_BITS'(sel.w);
  end

endmodule

// File: rtl/online_sd_adder_serial.sv
// Digit-serial MSD-first online adder for radix-2^(RADIX_BITS-1) signed-digit words.
// Latency: result position j is valid the cycle after digit j is accepted; N+1 cycles per word.
// Backpressure: while out_valid && !out_ready every register holds and in_ready is low.
// Ports: clk/rst (sync, active-high); in_valid/in_ready, din1, din2, cin (sampled with digit N-1);
//        dout/out_valid/out_ready with out_first (position 0) and out_last (position N).
// Optional: define ONLINE_ADDER_SUB_EN to add input 'sub' (taken with digit 0) for A-B-cin.
module online_sd_adder_serial
  import online_arith_pkg::*;
#(
  parameter int NUM_DIGITS = 8,   // at least 2
  parameter int RADIX_BITS = 3    // at least 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RADIX_BITS-1:0] din1,
  input  logic [RADIX_BITS-1:0] din2,
  input  logic [RADIX_BITS-1:0] cin,
  output logic [RADIX_BITS-1:0] dout,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef ONLINE_ADDER_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_first,
  output logic                  out_last
);

  localparam int             CW       = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(NUM_DIGITS - 1);

  adder_state_t          state;
  logic [CW-1:0]         cnt;
  logic [RADIX_BITS-1:0] w_pend;
  logic [RADIX_BITS-1:0] cin_reg;

  logic                  slot_free;
  logic                  accept;
  logic                  neg_now;
  logic [RADIX_BITS-1:0] b_eff;
  logic [RADIX_BITS-1:0] cin_eff;
  logic [1:0]            t_new;
  logic [RADIX_BITS-1:0] w_new;
  logic signed [RADIX_BITS:0] sum_mid;
  logic signed [RADIX_BITS:0] sum_last;

`ifdef ONLINE_ADDER_SUB_EN
  logic sub_reg;
  // Digit 0 uses the live sub; later digits use the value captured with digit 0,
  // so a mid-word change of sub has no effect.
  assign neg_now = (cnt == '0) ? sub : sub_reg;
`else
  assign neg_now = 1'b0;
`endif

  // Digit set is symmetric, so negation never overflows the digit width.
  assign b_eff   = neg_now ? RADIX_BITS'(-$signed(din2)) : din2;
  assign cin_eff = neg_now ? RADIX_BITS'(-$signed(cin))  : cin;

  sd_digit_select #(.RADIX_BITS(RADIX_BITS)) u_sel (
    .a (din1),
    .b (b_eff),
    .t (t_new),
    .w (w_new)
  );

  always_comb begin
    sum_mid  = (RADIX_BITS+1)'($signed(w_pend)) + (RADIX_BITS+1)'($signed(t_new));
    sum_last = (RADIX_BITS+1)'($signed(w_pend)) + (RADIX_BITS+1)'($signed(cin_reg));
  end

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && (state != FLUSH) && !rst;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      w_pend    <= '0;
      cin_reg   <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
`ifdef ONLINE_ADDER_SUB_EN
      sub_reg   <= 1'b0;
`endif
    end else if (accept) begin
      // Position cnt: bare transfer for the integer digit, else previous interim + transfer.
      out_valid <= 1'b1;
      out_first <= (cnt == '0);
      out_last  <= 1'b0;
      dout      <= (cnt == '0) ? RADIX_BITS'($signed(t_new)) : RADIX_BITS'(sum_mid);
      w_pend    <= w_new;
      if (cnt == CNT_LAST) begin
        cin_reg <= cin_eff;
        cnt     <= '0;
        state   <= FLUSH;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (cnt == '0) begin
        state <= RUN;
`ifdef ONLINE_ADDER_SUB_EN
        sub_reg <= sub;
`endif
      end
    end else if (state == FLUSH && slot_free) begin
      // Final position folds the word carry-in into the last interim digit.
      out_valid <= 1'b1;
      out_first <= 1'b0;
      out_last  <= 1'b1;
      dout      <= RADIX_BITS'(sum_last);
      state     <= IDLE;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_online_sd_adder_serial.sv
// Bench for online_sd_adder_serial: directed words with hand-computed digit streams,
// stall and reset cases, then random words checked by numeric word value.
module tb_online_sd_adder_serial;

  localparam int N  = 8;
  localparam int RB = 3;
  localparam int R  = 4;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [RB-1:0] din1, din2, cin, dout;
  logic out_valid, out_ready, out_first, out_last;
`ifdef ONLINE_ADDER_SUB_EN
  logic sub;
`endif

  always #5 clk = ~clk;

  online_sd_adder_serial #(.NUM_DIGITS(N), .RADIX_BITS(RB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din1      (din1),
    .din2      (din2),
    .cin       (cin),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ONLINE_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_first (out_first),
    .out_last  (out_last)
  );

  typedef struct {
    int d;
    bit first;
    bit last;
    bit chk;
  } exp_t;

  exp_t exp_q[$];
  int   val_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rnd_ready = 1'b0;
  int   mon_pos = 0;
  int   mon_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: a transfer happens at the posedge following this sample point.
  initial begin
    int   dv;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        dv = int'($signed(dout));
        chk("output_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_first", int'(out_first), int'(e.first));
          chk("out_last", int'(out_last), int'(e.last));
          if (e.chk) chk("digit", dv, e.d);
        end
        chk("digit_range", int'(dv >= -(R-1) && dv <= R-1), 1);
        mon_acc = mon_acc * R + dv;
        mon_pos++;
        if (out_last) begin
          chk("word_expected", int'(val_q.size() > 0), 1);
          if (val_q.size() > 0) chk("word_value", mon_acc, val_q.pop_front());
          mon_acc = 0;
          mon_pos = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at a negedge; returns at the negedge after the digit was accepted.
  task automatic send_digit(input int a, input int b, input int c, output int acc_cyc);
    int n;
    in_valid = 1'b1;
    din1 = RB'(a);
    din2 = RB'(b);
    cin  = RB'(c);
    #1;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("in_ready_within_bound", int'(n < 500), 1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input int a[N], input int b[N], input int c, input bit sb,
                           input bit chk_d, input int e[N+1], output int c0);
    int   v;
    int   tmp;
    exp_t x;
    v = 0;
    for (int j = 0; j < N; j++) v = v * R + a[j] + (sb ? -b[j] : b[j]);
    v = v + (sb ? -c : c);
    for (int p = 0; p <= N; p++) begin
      x.d = e[p];
      x.first = (p == 0);
      x.last = (p == N);
      x.chk = chk_d;
      exp_q.push_back(x);
    end
    val_q.push_back(v);
`ifdef ONLINE_ADDER_SUB_EN
    sub = sb;
`endif
    c0 = 0;
    for (int j = 0; j < N; j++) begin
      // cin is driven with noise on every beat except the one carrying digit N-1.
      send_digit(a[j], b[j], (j == N-1) ? c : int'($urandom_range(0, 2)) - 1, tmp);
      if (j == 0) c0 = tmp;
`ifdef ONLINE_ADDER_SUB_EN
      sub = ~sb;
`endif
    end
  endtask

  task automatic fill(input int v, output int arr[N]);
    for (int j = 0; j < N; j++) arr[j] = v;
  endtask

  initial begin
    int   a[N];
    int   b[N];
    int   e[N+1];
    int   z[N+1];
    int   c0a, c0b, tmp, c;
    bit   sb;
    bit   found;
    exp_t x;

    rst = 1'b1; in_valid = 1'b0; din1 = '0; din2 = '0; cin = '0; out_ready = 1'b1;
`ifdef ONLINE_ADDER_SUB_EN
    sub = 1'b0;
`endif
    for (int p = 0; p <= N; p++) z[p] = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_dout", int'(dout), 0);
    chk("reset_out_first", int'(out_first), 0);
    chk("reset_out_last", int'(out_last), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", int'(in_ready), 1);
    @(negedge clk);

    // Large positive digits: every transfer +1, interim 2.
    fill(3, a); fill(3, b);
    e = '{1, 3, 3, 3, 3, 3, 3, 3, 2};
    send_word(a, b, 0, 1'b0, 1'b1, e, c0a);

    // Large negative digits, issued back to back to measure the word bubble.
    fill(-3, a); fill(-3, b);
    e = '{-1, -3, -3, -3, -3, -3, -3, -3, -2};
    send_word(a, b, 0, 1'b0, 1'b1, e, c0b);
    chk("word_spacing_cycles", c0b - c0a, N + 1);

    // Small sums take the t=0 path; cin lands in the final digit.
    fill(1, a); fill(1, b);
    e = '{0, 2, 2, 2, 2, 2, 2, 2, 3};
    send_word(a, b, 1, 1'b0, 1'b1, e, tmp);

    // Stall for 3 cycles while position 4 is presented.
    fill(3, a); fill(3, b);
    e = '{1, 3, 3, 3, 3, 3, 3, 3, 2};
    fork
      send_word(a, b, 0, 1'b0, 1'b1, e, tmp);
      begin
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
          @(negedge clk);
          if (out_valid && mon_pos == 4) found = 1'b1;
        end
        chk("stall_position_seen", int'(found), 1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("stall_in_ready", int'(in_ready), 0);
          chk("stall_out_valid", int'(out_valid), 1);
          chk("stall_dout_held", int'($signed(dout)), 3);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join

    // Reset after 4 digits of a word; positions 0..3 have been emitted by then.
    for (int p = 0; p < 4; p++) begin
      x.d = (p == 0) ? 1 : 3;
      x.first = (p == 0);
      x.last = 1'b0;
      x.chk = 1'b1;
      exp_q.push_back(x);
    end
    for (int j = 0; j < 4; j++) send_digit(3, 3, 0, tmp);
    rst = 1'b1;
    #1;
    chk("midword_reset_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    mon_acc = 0;
    mon_pos = 0;
    #1;
    chk("post_reset_out_valid", int'(out_valid), 0);
    chk("post_reset_no_pending", exp_q.size(), 0);
    @(negedge clk);
    fill(1, a); fill(1, b);
    e = '{0, 2, 2, 2, 2, 2, 2, 2, 3};
    send_word(a, b, 1, 1'b0, 1'b1, e, tmp);

    // Random back-to-back words under random downstream backpressure.
    rnd_ready = 1'b1;
    for (int w = 0; w < 1000; w++) begin
      for (int j = 0; j < N; j++) begin
        a[j] = int'($urandom_range(0, 6)) - 3;
        b[j] = int'($urandom_range(0, 6)) - 3;
      end
      c = int'($urandom_range(0, 2)) - 1;
      sb = 1'b0;
`ifdef ONLINE_ADDER_SUB_EN
      sb = 1'($urandom_range(0, 1));
`endif
      send_word(a, b, c, sb, 1'b0, z, tmp);
    end

    for (int k = 0; k < 2000 && exp_q.size() > 0; k++) @(negedge clk);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    chk("drain_digits_left", exp_q.size(), 0);
    chk("drain_words_left", val_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/online_sd_adder_serial.md
Name: online_sd_adder_serial

Overview:
- Digit-serial, MSD-first online adder for radix-2^k signed-digit operands.
- Successor to the parallel carry-free radix-4 adder. Same transfer/interim-sum split, but digits arrive one per beat and the result streams out with online delay 1.
- Generalised in radix and word length; valid/ready handshake on both sides.
- Sits between online multiplier/divider stages in the digit-serial datapath.

Parameters:
- NUM_DIGITS, 8: digits per input word, N. Must be at least 2.
- RADIX_BITS, 3: bits per digit, two's complement. Must be at least 3.
- RADIX (localparam), 2**(RADIX_BITS-1): radix r. Digit set is [-(r-1), r-1].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input digit pair valid.
- in_ready  out  1  adder can accept a digit pair.
- din1  in  RADIX_BITS  operand A digit, signed.
- din2  in  RADIX_BITS  operand B digit, signed.
- cin  in  RADIX_BITS  word carry-in digit in {-1,0,1}; sampled only on the beat that accepts digit N-1.
- dout  out  RADIX_BITS  result digit, signed.
- out_valid  out  1  dout valid.
- out_ready  in  1  downstream accepts dout.
- out_first  out  1  dout is result position 0 (integer/transfer digit).
- out_last  out  1  dout is result position N (final digit of the word).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on rst.
- Transfer/interim selection per accepted digit j. Let s = din1 + din2.
  - If s >= r-1: t_j = +1, w_j = s - r.
  - Else if s <= -(r-1): t_j = -1, w_j = s + r.
  - Else: t_j = 0, w_j = s.
  - Guarantees |w_j| <= r-2, so every output digit lies in [-(r-1), r-1] with no overflow.
- Result stream has N+1 digits, positions 0..N:
  - Position 0 = t_0.
  - Position j (1..N-1) = w_{j-1} + t_j.
  - Position N = w_{N-1} + cin.
- Registers: one output register (dout/out_valid/out_first/out_last), w_pend, cin_reg, digit counter cnt (0..N-1).
- FSM states:
  - IDLE: no pending interim.
  - RUN: w_pend holds w of the last accepted digit.
  - FLUSH: digit N-1 accepted; only position N remains to emit.
- Output slot is free when !out_valid || out_ready.
- in_ready = slot free && state != FLUSH.
- Accept rule (in_valid && in_ready):
  - Load the output register with position cnt.
  - w_pend <= w_j; cnt <= cnt+1.
  - When cnt == N-1: latch cin, clear cnt, go to FLUSH.
  - When cnt == 0: IDLE -> RUN.
- FLUSH with slot free: load position N (w_pend + cin_reg, out_last=1), go to IDLE.
- Output register drops out_valid when out_ready && nothing new is loaded.
- Latency: position j is valid the cycle after digit j is accepted. Position N appears one cycle after position N-1 if out_ready is held.
- Throughput: N+1 cycles per word, with exactly one input bubble per word.
- Backpressure: while out_valid && !out_ready, all registers hold and in_ready is 0.
- Reset, including mid-word: out_valid=0, out_first=0, out_last=0, dout=0, in_ready=0 during reset, cnt=0, w_pend=0, cin_reg=0, state=IDLE. The partial word is discarded and the next accepted digit is digit 0.
- Arithmetic is done in RADIX_BITS+1 bits signed, then truncated to RADIX_BITS.

Optional Feature:
- Macro ONLINE_ADDER_SUB_EN.
- Defined:
  - Adds port sub (in, 1). sub is sampled on the beat accepting digit 0 and held for the word.
  - When set, din2 and cin are negated before selection, so the result is A-B-cin.
  - A sub change mid-word is ignored.
- Undefined: port absent; always adds.

Decomposition:
- Package online_arith_pkg holds:
  - digit width/radix helper functions;
  - the state enum {IDLE, RUN, FLUSH};
  - function sd_select(s) returning {t, w}, shared with future multi-operand adders.
- One sub-module, sd_digit_select: combinational selection of t_j, w_j for one digit pair.
- FSM, counter and handshake live in the top module.

Test Plan:
- r=4, N=8, all din1=din2=3, cin=0 -> dout stream 1,3,3,3,3,3,3,3,2; out_first on the 1st digit, out_last on the 9th.
- All din1=din2=-3, cin=0 -> stream -1,-3,-3,-3,-3,-3,-3,-3,-2.
- All din1=din2=1, cin=1 -> stream 0,2,2,2,2,2,2,2,3. Checks the small-sum path (t=0) and cin folding.
- out_ready low for 3 cycles after position 4 -> in_ready=0 for those cycles; dout held stable; stream identical to the unstalled run.
- rst pulsed after 4 digits accepted -> next cycle out_valid=0; the following word's first output has out_first=1 and a correct value.
- 1000 random back-to-back words with random out_ready:
  - numeric value of the result equals A+B+cin;
  - every digit within [-3,3];
  - exactly one bubble between words;
  - with ONLINE_ADDER_SUB_EN, sub=1 words equal A-B-cin.
